// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the core pipeline sequencer
// Contents: hazard_state_t (sequencer FSM states), regaddr_t (register specifier),
//           REG_ZERO (hard-wired zero register).
package cpu_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    typedef logic [DEF_REG_ADDR_W-1:0] regaddr_t;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
    localparam regaddr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports: clk, rst_n (async active-low), clr (sync clear, wins over inc),
//        inc (count enable), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline sequencer: load-use stall, branch flush, memory freeze
// Ports: clk, rst_n (async active-low);
//        hazard inputs id_rs/id_rt/id_usesRt, ex_memRead/ex_rt, branchTaken, dmemReq/dmemReady;
//        clearCounters (sync clear of both counters);
//        enables pcWrite/ifIdWrite/idExWrite/exMemWrite, inhibitControl, ifIdFlush;
//        memError (sticky timeout flag), stallCycles/flushCount (saturating counters).
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_usesRt,
    input  logic                  ex_memRead,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  branchTaken,
    input  logic                  dmemReq,
    input  logic                  dmemReady,
    input  logic                  clearCounters,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  idExWrite,
    output logic                  exMemWrite,
    output logic                  inhibitControl,
    output logic                  ifIdFlush,
    output logic                  memError,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     r_state;
    hazard_state_t     w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_error;
    logic              w_mem_error_nxt;

    logic w_mem_stall;
    logic w_freeze;
    logic w_ex_rt_nonzero;
    logic w_load_use;
    logic w_stall_inc;

    assign w_mem_stall     = dmemReq & ~dmemReady;
    assign w_freeze        = w_mem_stall | (r_state == ERROR);
    assign w_ex_rt_nonzero = (ex_rt != REG_ADDR_W'(REG_ZERO));
    assign w_load_use      = ex_memRead & w_ex_rt_nonzero &
                             ((ex_rt == id_rs) | (id_usesRt & (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_error <= w_mem_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_error_nxt = r_mem_error;
        pcWrite         = 1'b1;
        ifIdWrite       = 1'b1;
        idExWrite       = 1'b1;
        exMemWrite      = 1'b1;
        inhibitControl  = 1'b0;
        ifIdFlush       = 1'b0;

        // waitCnt counts wait cycles already spent, so the first stalled cycle in RUN loads 1.
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end
            end
            WAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt     = ERROR;
                    w_mem_error_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            ERROR: begin
                w_mem_error_nxt = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase

        // Outputs stay at their free-running defaults while reset is held.
        if (rst_n) begin
            if (w_freeze) begin
                pcWrite    = 1'b0;
                ifIdWrite  = 1'b0;
                idExWrite  = 1'b0;
                exMemWrite = 1'b0;
            end else if (w_load_use) begin
                // Bubble into EX; a concurrent taken branch is ignored because its
                // operands depend on the load and it re-resolves next cycle.
                pcWrite        = 1'b0;
                ifIdWrite      = 1'b0;
                inhibitControl = 1'b1;
            end else if (branchTaken) begin
                ifIdFlush = 1'b1;
            end
        end
    end

    assign memError    = r_mem_error;
    assign w_stall_inc = ~pcWrite;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clearCounters),
        .inc  (w_stall_inc),
        .count(stallCycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clearCounters),
        .inc  (ifIdFlush),
        .count(flushCount)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - self-checking bench for hazard_controller
module tb_hazard_controller;

    localparam int RW   = 5;
    localparam int TO   = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] id_rs, id_rt, ex_rt;
    logic          id_usesRt, ex_memRead, branchTaken, dmemReq, dmemReady, clearCounters;
    logic          pcWrite, ifIdWrite, idExWrite, exMemWrite, inhibitControl, ifIdFlush, memError;
    logic [CW-1:0] stallCycles, flushCount;

    always #5 clk = ~clk;

    hazard_controller #(
        .REG_ADDR_W (RW),
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_usesRt     (id_usesRt),
        .ex_memRead    (ex_memRead),
        .ex_rt         (ex_rt),
        .branchTaken   (branchTaken),
        .dmemReq       (dmemReq),
        .dmemReady     (dmemReady),
        .clearCounters (clearCounters),
        .pcWrite       (pcWrite),
        .ifIdWrite     (ifIdWrite),
        .idExWrite     (idExWrite),
        .exMemWrite    (exMemWrite),
        .inhibitControl(inhibitControl),
        .ifIdFlush     (ifIdFlush),
        .memError      (memError),
        .stallCycles   (stallCycles),
        .flushCount    (flushCount)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: error flag, length of the current unanswered-memory run, counter tallies.
    bit m_err;
    int m_wait_run;
    int m_stall;
    int m_flush;

    task automatic model_reset();
        m_err      = 1'b0;
        m_wait_run = 0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {26'd0, pcWrite, ifIdWrite, idExWrite, exMemWrite, inhibitControl, ifIdFlush};
    endfunction

    // One clock cycle: apply inputs, check the combinational controls, then clock and
    // check the registered outputs against the model.
    task automatic cycle(input string tag, input logic mr, input logic [RW-1:0] ert,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic ur,
                         input logic br, input logic rq, input logic rd, input logic cl);
        bit          frz, lu;
        logic [31:0] exp;
        ex_memRead    = mr;
        ex_rt         = ert;
        id_rs         = rs;
        id_rt         = rt;
        id_usesRt     = ur;
        branchTaken   = br;
        dmemReq       = rq;
        dmemReady     = rd;
        clearCounters = cl;
        #1;
        frz = (rq && !rd) || m_err;
        lu  = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
        if (frz)     exp = 32'b000000;
        else if (lu) exp = 32'b001110;
        else if (br) exp = 32'b111101;
        else         exp = 32'b111100;
        chk({tag, "/ctl"}, ctl_vec(), exp);
        @(posedge clk);
        if (cl) m_stall = 0;
        else if (exp[5] == 1'b0 && m_stall < CMAX) m_stall++;
        if (cl) m_flush = 0;
        else if (exp[0] == 1'b1 && m_flush < CMAX) m_flush++;
        if (!m_err) begin
            if (rq && !rd) begin
                m_wait_run++;
                if (m_wait_run >= TO) m_err = 1'b1;
            end else begin
                m_wait_run = 0;
            end
        end
        #1;
        chk({tag, "/stall"}, 32'(stallCycles), 32'(m_stall));
        chk({tag, "/flush"}, 32'(flushCount), 32'(m_flush));
        chk({tag, "/memerr"}, 32'(memError), 32'(m_err));
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        ex_memRead    = 1'b1;
        ex_rt         = 5'd5;
        id_rs         = 5'd5;
        id_rt         = 5'd0;
        id_usesRt     = 1'b0;
        branchTaken   = 1'b1;
        dmemReq       = 1'b1;
        dmemReady     = 1'b0;
        clearCounters = 1'b0;
        model_reset();

        // Outputs forced and counters held at zero while in reset, even with hazards present.
        #2;
        chk("reset/ctl", ctl_vec(), 32'b111100);
        chk("reset/memerr", 32'(memError), 32'd0);
        @(posedge clk);
        #1;
        chk("reset/stall", 32'(stallCycles), 32'd0);
        chk("reset/flush", 32'(flushCount), 32'd0);
        rst_n = 1'b1;

        // Load-use on rs, then the load moves on to MEM.
        cycle("lu_rs5", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs5/const", 32'(stallCycles), 32'd1);
        idle("lu_rs5_next");

        // Register-0 load and an unused rt match do not stall.
        cycle("lw0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lw7_nort", 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lw7_rt", 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_rt/const", 32'(stallCycles), 32'd2);

        // Taken branch flushes; with a load-use in the same cycle only the stall happens.
        cycle("br", 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br/const", 32'(flushCount), 32'd1);
        cycle("br_lu", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("br_lu/const", 32'(flushCount), 32'd1);

        // Memory wait of three cycles, answered on the fourth.
        cycle("clr", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle("memwait", 1'b0, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("memready", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("memwait/const", 32'(stallCycles), 32'd3);

        // Memory never answers: ERROR after TO wait cycles, then frozen regardless of inputs.
        for (int i = 0; i < TO; i++)
            cycle("timeout", 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("timeout/const", 32'(memError), 32'd1);
        for (int i = 0; i < 4; i++)
            cycle("error_hold", 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("error_sat/const", 32'(stallCycles), 32'(CMAX));

        // Asynchronous reset mid-cycle while in ERROR.
        branchTaken = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("err_reset/memerr", 32'(memError), 32'd0);
        chk("err_reset/stall", 32'(stallCycles), 32'd0);
        chk("err_reset/flush", 32'(flushCount), 32'd0);
        chk("err_reset/ctl", ctl_vec(), 32'b111100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("after_reset");

        // Saturation and clear-over-increment.
        for (int i = 0; i < CMAX + 5; i++)
            cycle("sat", 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat/const", 32'(stallCycles), 32'(CMAX));
        cycle("clr_stall", 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_stall/const", 32'(stallCycles), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  1'($urandom_range(0, 1)),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  RW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
